gcd_engine: RTL

GCD_ENGINE -- requirements
Module: gcd_engine

---
 rtl/gcd_engine_if.sv | 37 +++
 rtl/gcd_engine.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/gcd_engine_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : gcd_engine_if
//  Description : Handshake and data bundle for gcd_engine.
//                master - operand producer / result consumer
//                slave  - the GCD engine
//  Signals     : in_valid/in_ready    operand-pair handshake
//                data_in1/data_in2    operands A and B (WIDTH bits)
//                out_valid/out_ready  result handshake
//                result               GCD value (WIDTH bits)
//                iter_count           CALC steps taken (WIDTH+1 bits)
//  Revision    : 1.0 - initial release
// ============================================================================
interface gcd_engine_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_in1;
  logic [WIDTH-1:0] data_in2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH:0]   iter_count;

  modport master (
    output in_valid, data_in1, data_in2, out_ready,
    input  in_ready, out_valid, result, iter_count
  );

  modport slave (
    input  in_valid, data_in1, data_in2, out_ready,
    output in_ready, out_valid, result, iter_count
  );
endinterface
`default_nettype wire

// File: rtl/gcd_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : gcd_engine
//  Description : Iterative GCD engine, one algorithm step per clock.
//                MODE 0 = subtractive Euclid, MODE 1 = binary Stein.
//  Ports       : clk            rising-edge clock
//                rst            asynchronous active-high reset
//                bus (slave)    operand/result handshake, see gcd_engine_if
//  Option      : GCD_DEBUG_EN adds state_ctrl[3:0] (IDLE=0, CALC=1, DONE=2),
//                a_reg_check and b_reg_check (live A and B).
//  Revision    : 1.0 - initial release
// ============================================================================
module gcd_engine #(
  parameter int WIDTH = 8,
  parameter int MODE  = 0
) (
  input  logic             clk,
  input  logic             rst,
  gcd_engine_if.slave      bus
`ifdef GCD_DEBUG_EN
  ,
  output logic [3:0]       state_ctrl,
  output logic [WIDTH-1:0] a_reg_check,
  output logic [WIDTH-1:0] b_reg_check
`endif
);

  // k counts common factors of two; at most WIDTH-1 of them exist.
  localparam int K_W = $clog2(WIDTH) + 1;

  localparam logic [WIDTH:0] c_iter_one = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [K_W-1:0] c_k_one    = {{(K_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [K_W-1:0]   r_k;

  logic             w_eq;
  logic             w_zero;
  logic [WIDTH-1:0] w_a_minus_b;
  logic [WIDTH-1:0] w_b_minus_a;
  logic [WIDTH-1:0] w_a_nxt;
  logic [WIDTH-1:0] w_b_nxt;
  logic [K_W-1:0]   w_k_nxt;
  logic [WIDTH-1:0] w_eq_result;
  logic [WIDTH:0]   w_iter_nxt;

  assign w_eq        = (r_a == r_b);
  assign w_zero      = (r_a == '0) || (r_b == '0);
  assign w_a_minus_b = r_a - r_b;
  assign w_b_minus_a = r_b - r_a;
  assign w_iter_nxt  = (bus.iter_count == '1) ? bus.iter_count
                                              : bus.iter_count + c_iter_one;

  generate
    if (MODE == 0) begin : g_subtractive
      assign w_eq_result = r_a;
      assign w_k_nxt     = r_k;
      assign w_a_nxt     = (r_a > r_b) ? w_a_minus_b : r_a;
      assign w_b_nxt     = (r_a > r_b) ? r_b : w_b_minus_a;
    end else begin : g_binary
      // Shifting back by k cannot overflow: the result never exceeds the
      // smaller nonzero operand.
      assign w_eq_result = r_a << r_k;

      always_comb begin
        w_a_nxt = r_a;
        w_b_nxt = r_b;
        w_k_nxt = r_k;
        if (!r_a[0] && !r_b[0]) begin
          w_a_nxt = r_a >> 1;
          w_b_nxt = r_b >> 1;
          w_k_nxt = r_k + c_k_one;
        end else if (!r_a[0]) begin
          w_a_nxt = r_a >> 1;
        end else if (!r_b[0]) begin
          w_b_nxt = r_b >> 1;
        end else if (r_a > r_b) begin
          // Difference of two odd numbers is even, so halve it at once.
          w_a_nxt = w_a_minus_b >> 1;
        end else begin
          w_b_nxt = w_b_minus_a >> 1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_a            <= '0;
      r_b            <= '0;
      r_k            <= '0;
      bus.result     <= '0;
      bus.iter_count <= '0;
      bus.out_valid  <= 1'b0;
      bus.in_ready   <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_a            <= bus.data_in1;
            r_b            <= bus.data_in2;
            r_k            <= '0;
            bus.iter_count <= '0;
            bus.in_ready   <= 1'b0;
            r_state        <= ST_CALC;
          end
        end
        ST_CALC: begin
          bus.iter_count <= w_iter_nxt;
          if (w_zero) begin
            bus.result    <= r_a | r_b;
            bus.out_valid <= 1'b1;
            r_state       <= ST_DONE;
          end else if (w_eq) begin
            bus.result    <= w_eq_result;
            bus.out_valid <= 1'b1;
            r_state       <= ST_DONE;
          end else begin
            r_a <= w_a_nxt;
            r_b <= w_b_nxt;
            r_k <= w_k_nxt;
          end
        end
        ST_DONE: begin
          // in_ready comes back one cycle after the result handshake.
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            r_state       <= ST_IDLE;
          end
        end
        default: begin
          r_state       <= ST_IDLE;
          bus.out_valid <= 1'b0;
          bus.in_ready  <= 1'b1;
        end
      endcase
    end
  end

`ifdef GCD_DEBUG_EN
  assign state_ctrl  = {2'b00, r_state};
  assign a_reg_check = r_a;
  assign b_reg_check = r_b;
`endif

endmodule
`default_nettype wire
